// File: rtl/display_uart_pkg.sv
// Shared types and ASCII constants for the display UART streamer.
package display_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND   = 3'd2,
    STROBE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  // 'A' minus 10, so a nibble of 10..15 maps straight onto 'A'..'F'
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

endpackage

// File: rtl/display_uart_tx_hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii
  import display_uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits 0-9 offset from '0', 10-15 offset so they land on 'A'-'F'.
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'b0000, nibble};
    else                ascii = ASCII_A_M10 + {4'b0000, nibble};
  end

endmodule

// File: rtl/display_uart_tx.sv
// Streams the CPU display word to the UART byte port as ASCII hex,
// MSB nibble first, optionally terminated with CR LF.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame; watch for value change, pending request
// LOAD   | capture value into snapshot/last_sent, clear pending
// SEND   | wait for txready, then present char(idx) and raise txclk
// STROBE | txclk high for this single cycle
// WAIT   | wait for the UART to drop txready (byte accepted)
// DONE   | frame_done high for one cycle
module display_uart_tx
  import display_uart_pkg::*;
#(
  parameter int WIDTH     = 32,   // must be a multiple of 4
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  input  logic             send_req,
  input  logic             txready,
  output logic [7:0]       txdata,
  output logic             txclk,
  output logic             busy,
  output logic             frame_done
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES + 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1 + 2 * int'(SEND_CRLF));

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] snapshot;
  logic [WIDTH-1:0] last_sent;
  logic             pending;

  logic             start_frame;
  logic             byte_go;
  logic             byte_acked;
  logic             last_byte;
  logic [3:0]       nibble;
  logic [7:0]       digit_char;
  logic [7:0]       next_char;
  int               idx_int;

  assign start_frame = enable && (pending || (value != last_sent));
  assign byte_go     = (state == SEND) && txready;
  assign byte_acked  = (state == WAIT) && !txready;
  assign last_byte   = (idx == LAST);
  assign idx_int     = int'({{(32-IDX_W){1'b0}}, idx});

  // Pick the snapshot nibble addressed by idx, MSB nibble at idx 0.
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) nibble = snapshot[WIDTH-1-4*i -: 4];
    end
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble (nibble),
    .ascii  (digit_char)
  );

  // Character for the current index: hex digit, then CR, then LF.
  always_comb begin
    next_char = ASCII_LF;
    if (idx_int < NIBBLES)       next_char = digit_char;
    else if (idx_int == NIBBLES) next_char = ASCII_CR;
  end

  // Next-state decode for the byte handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_frame) next_state = LOAD;
      LOAD:    next_state = SEND;
      SEND:    if (txready) next_state = STROBE;
      STROBE:  next_state = WAIT;
      WAIT:    if (!txready) next_state = last_byte ? DONE : SEND;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Frame capture and character index; the frame only ever reads snapshot,
  // so value may move freely while a frame is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot  <= '0;
      last_sent <= '0;
      idx       <= '0;
    end else if (state == LOAD) begin
      snapshot  <= value;
      last_sent <= value;
      idx       <= '0;
    end else if (byte_acked && !last_byte) begin
      idx <= idx + 1'b1;
    end
  end

  // Sticky resend request; a request landing in LOAD itself is kept so it
  // produces one further frame rather than being lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pending <= 1'b1;
    else if (send_req)         pending <= 1'b1;
    else if (state == LOAD)    pending <= 1'b0;
  end

  // Registered outputs; txdata holds its last byte between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txdata     <= 8'h00;
      txclk      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      txclk      <= byte_go;
      busy       <= (next_state != IDLE);
      frame_done <= (next_state == DONE);
      if (byte_go) txdata <= next_char;
    end
  end

endmodule

// File: tb/tb_display_uart_tx.sv
// Self-checking bench for display_uart_tx: a CRLF instance and a
// digits-only instance, each driven by a simple UART ready/strobe model.
module tb_display_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, enable0;
  logic        send_req, send_req0;
  logic [31:0] value;
  logic        rdy1_m = 1'b1;
  logic        rdy0_m = 1'b1;
  logic        stall;
  logic        txready1, txready0;
  logic [7:0]  txdata1, txdata0;
  logic        txclk1, txclk0, busy1, busy0, fd1, fd0;

  int n_tests = 0;
  int n_fail  = 0;

  int drop_min = 2, drop_max = 2, back_min = 5, back_max = 5;
  int dcnt1 = 0, bcnt1 = 0, dcnt0 = 0, bcnt0 = 0;
  int cyc = 0, last1 = -100, strobes1 = 0, fd1_cnt = 0, fd0_cnt = 0;
  logic prev1 = 1'b0, prev0 = 1'b0;

  logic [7:0] got1[$], got0[$], exp1[$], exp0[$];

  always #5 clk = ~clk;

  assign txready1 = rdy1_m & ~stall;
  assign txready0 = rdy0_m;

  display_uart_tx #(.WIDTH(32), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value),
    .send_req(send_req), .txready(txready1), .txdata(txdata1),
    .txclk(txclk1), .busy(busy1), .frame_done(fd1)
  );

  display_uart_tx #(.WIDTH(32), .SEND_CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .value(value),
    .send_req(send_req0), .txready(txready0), .txdata(txdata0),
    .txclk(txclk0), .busy(busy0), .frame_done(fd0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference frame: hex digits from plain arithmetic, then optional CR LF.
  function automatic void add_frame(input bit which, input logic [31:0] v, input bit crlf);
    logic [7:0] c;
    int d;
    for (int k = 7; k >= 0; k--) begin
      d = int'((v >> (4 * k)) % 32'd16);
      c = (d < 10) ? 8'(48 + d) : 8'(55 + d);
      if (which) exp1.push_back(c); else exp0.push_back(c);
    end
    if (crlf) begin
      if (which) begin exp1.push_back(8'h0D); exp1.push_back(8'h0A); end
      else       begin exp0.push_back(8'h0D); exp0.push_back(8'h0A); end
    end
  endfunction

  task automatic compare_bytes(input string tag, input bit which);
    int n;
    if (which) begin
      chk({tag, "_count"}, 32'(got1.size()), 32'(exp1.size()));
      n = (got1.size() < exp1.size()) ? got1.size() : exp1.size();
      for (int i = 0; i < n; i++) chk(tag, 32'(got1[i]), 32'(exp1[i]));
      got1.delete(); exp1.delete();
    end else begin
      chk({tag, "_count"}, 32'(got0.size()), 32'(exp0.size()));
      n = (got0.size() < exp0.size()) ? got0.size() : exp0.size();
      for (int i = 0; i < n; i++) chk(tag, 32'(got0[i]), 32'(exp0[i]));
      got0.delete(); exp0.delete();
    end
  endtask

  task automatic wait_quiet(input bit which);
    int quiet = 0;
    for (int t = 0; t < 4000 && quiet < 12; t++) begin
      @(negedge clk);
      if (which ? (!busy1 && txready1) : (!busy0 && txready0)) quiet++;
      else quiet = 0;
    end
    chk("quiet_timeout", 32'(quiet), 32'd12);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (got1.size() < n && t < 2000) begin @(negedge clk); t++; end
    chk("byte_wait_timeout", 32'(got1.size() >= n), 32'd1);
  endtask

  task automatic pulse_req(input bit which);
    if (which) send_req = 1'b1; else send_req0 = 1'b1;
    @(negedge clk);
    send_req = 1'b0; send_req0 = 1'b0;
  endtask

  // UART model for the CRLF instance: ready drops after a strobe, returns later.
  always @(negedge clk) begin
    if (reset) begin
      rdy1_m = 1'b1; dcnt1 = 0; bcnt1 = 0;
    end else if (txclk1) begin
      dcnt1 = $urandom_range(drop_max, drop_min);
    end else if (dcnt1 > 0) begin
      dcnt1--;
      if (dcnt1 == 0) begin rdy1_m = 1'b0; bcnt1 = $urandom_range(back_max, back_min); end
    end else if (bcnt1 > 0) begin
      bcnt1--;
      if (bcnt1 == 0) rdy1_m = 1'b1;
    end
  end

  // UART model for the digits-only instance.
  always @(negedge clk) begin
    if (reset) begin
      rdy0_m = 1'b1; dcnt0 = 0; bcnt0 = 0;
    end else if (txclk0) begin
      dcnt0 = $urandom_range(drop_max, drop_min);
    end else if (dcnt0 > 0) begin
      dcnt0--;
      if (dcnt0 == 0) begin rdy0_m = 1'b0; bcnt0 = $urandom_range(back_max, back_min); end
    end else if (bcnt0 > 0) begin
      bcnt0--;
      if (bcnt0 == 0) rdy0_m = 1'b1;
    end
  end

  // Byte capture, strobe width/spacing and frame_done counting.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (txclk1) begin
        got1.push_back(txdata1);
        strobes1++;
        chk("txclk_width", 32'(prev1), 32'd0);
        chk("strobe_gap", 32'((cyc - last1) >= 3), 32'd1);
        last1 = cyc;
      end
      if (txclk0) begin
        got0.push_back(txdata0);
        chk("txclk0_width", 32'(prev0), 32'd0);
      end
      if (fd1) fd1_cnt++;
      if (fd0) fd0_cnt++;
    end
    prev1 = txclk1;
    prev0 = txclk0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, v2, last;
    logic [7:0]  held;
    int f, mode, bad_clk, bad_data, bad_busy, s0, t;

    reset = 1'b1; enable = 1'b1; enable0 = 1'b0;
    send_req = 1'b0; send_req0 = 1'b0; value = 32'h0; stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txdata", 32'(txdata1), 32'h0);
    chk("rst_txclk", 32'(txclk1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_frame_done", 32'(fd1), 32'h0);
    reset = 1'b0;

    // Forced frame after reset, value 0.
    add_frame(1'b1, 32'h0, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t1_bytes", 1'b1);
    chk("t1_frame_done", 32'(fd1_cnt), 32'd1);
    chk("t1_busy_after", 32'(busy1), 32'd0);

    // Latency and strobe count for a value change.
    s0 = strobes1;
    value = 32'h1234ABCD;
    @(negedge clk); chk("lat_edge_n", 32'(txclk1), 32'd0);
    @(negedge clk); chk("lat_edge_n1", 32'(txclk1), 32'd0);
    @(negedge clk); chk("lat_edge_n2", 32'(txclk1), 32'd1);
    add_frame(1'b1, 32'h1234ABCD, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t2_bytes", 1'b1);
    chk("t2_strobes", 32'(strobes1 - s0), 32'd10);

    // Value change mid-frame must not corrupt the frame in flight.
    f = fd1_cnt;
    pulse_req(1'b1);
    wait_bytes(3);
    value = 32'hDEADBEEF;
    add_frame(1'b1, 32'h1234ABCD, 1'b1);
    add_frame(1'b1, 32'hDEADBEEF, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t3_bytes", 1'b1);
    chk("t3_frame_done", 32'(fd1_cnt - f), 32'd2);

    // UART stalls in SEND for 50 cycles.
    v = $urandom; while (v == 32'hDEADBEEF) v = $urandom;
    value = v;
    wait_bytes(3);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    held = txdata1;
    bad_clk = 0; bad_data = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txclk1) bad_clk++;
      if (txdata1 != held) bad_data++;
      if (!busy1) bad_busy++;
    end
    chk("stall_txclk", 32'(bad_clk), 32'd0);
    chk("stall_txdata", 32'(bad_data), 32'd0);
    chk("stall_busy", 32'(bad_busy), 32'd0);
    stall = 1'b0;
    add_frame(1'b1, v, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t4_bytes", 1'b1);

    // Reset during the 5th byte.
    v2 = $urandom; while (v2 == v) v2 = $urandom;
    value = v2;
    wait_bytes(5);
    reset = 1'b1;
    #1;
    chk("midrst_txclk", 32'(txclk1), 32'd0);
    chk("midrst_busy", 32'(busy1), 32'd0);
    @(negedge clk); @(negedge clk);
    got1.delete(); exp1.delete();
    reset = 1'b0;
    add_frame(1'b1, v2, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t5_bytes", 1'b1);
    last = v2;

    // Digits-only instance: forced frame, resend, and request while busy.
    enable0 = 1'b1;
    add_frame(1'b0, value, 1'b0);
    wait_quiet(1'b0);
    compare_bytes("t6_first", 1'b0);
    f = fd0_cnt;
    pulse_req(1'b0);
    add_frame(1'b0, value, 1'b0);
    wait_quiet(1'b0);
    compare_bytes("t6_resend", 1'b0);
    chk("t6_fd_one", 32'(fd0_cnt - f), 32'd1);
    pulse_req(1'b0);
    t = 0;
    while (!busy0 && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    pulse_req(1'b0);
    add_frame(1'b0, value, 1'b0);
    add_frame(1'b0, value, 1'b0);
    wait_quiet(1'b0);
    compare_bytes("t6_busy_req", 1'b0);
    chk("t6_fd_three", 32'(fd0_cnt - f), 32'd3);
    enable0 = 1'b0;

    // enable dropped mid-frame: frame completes, nothing new until re-enabled.
    v = $urandom; while (v == last) v = $urandom;
    value = v;
    wait_bytes(2);
    enable = 1'b0;
    v2 = $urandom; while (v2 == v) v2 = $urandom;
    value = v2;
    add_frame(1'b1, v, 1'b1);
    wait_quiet(1'b1);
    repeat (20) @(negedge clk);
    compare_bytes("t7_disabled", 1'b1);
    enable = 1'b1;
    add_frame(1'b1, v2, 1'b1);
    wait_quiet(1'b1);
    compare_bytes("t7_reenabled", 1'b1);
    last = v2;

    // Randomized values, mid-frame changes/reverts and UART timing.
    drop_min = 1; drop_max = 3; back_min = 1; back_max = 6;
    for (int it = 0; it < 12; it++) begin
      v = $urandom; while (v == last) v = $urandom;
      value = v;
      add_frame(1'b1, v, 1'b1);
      mode = $urandom_range(2, 0);
      wait_bytes(2);
      v2 = $urandom; while (v2 == v) v2 = $urandom;
      if (mode == 1) begin
        value = v2;
        add_frame(1'b1, v2, 1'b1);
        last = v2;
      end else if (mode == 2) begin
        value = v2;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        value = v;
        last = v;
      end else begin
        last = v;
      end
      wait_quiet(1'b1);
      compare_bytes("rnd_bytes", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
- Sits downstream of the CPU core, beside the seven-segment mapping, on the same 32-bit `display` value.
- Streams that value to the board's UART byte port as ASCII hex: 8 characters MSB-first, optionally followed by CR LF.
- Starts a frame after reset, when the value changes, or on a manual request.
- A handshake FSM paces bytes against the UART's `txready`/`txclk` contract.

Parameters:
- WIDTH, 32, width of `value`; must be a multiple of 4. NIBBLES = WIDTH/4.
- SEND_CRLF, 1, 1: append 0x0D 0x0A after the hex digits. 0: digits only.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames.
- value  input  WIDTH  word to display (CPU `display` bus).
- send_req  input  1  single-cycle request to resend even if `value` is unchanged.
- txready  input  1  UART can accept a byte; drops low while the UART is busy.
- txdata  output  8  byte presented to the UART.
- txclk  output  1  one-cycle strobe; UART latches `txdata` on it.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse after the last byte of a frame.

Behaviour:
- **Reset.** Reset is asynchronous; all outputs are registered.
  - txdata=0, txclk=0, busy=0, frame_done=0.
  - state=IDLE, idx=0, snapshot=0, last_sent=0, pending=1.
  - pending=1 forces one frame after reset.
- **FSM states:** IDLE, LOAD, SEND, STROBE, WAIT, DONE.
- **IDLE**
  - Goes to LOAD when enable=1 and (pending=1 or value != last_sent).
  - send_req sets `pending` in any state. `pending` is sticky until LOAD.
- **LOAD:** snapshot<=value; last_sent<=value; pending<=0; idx<=0; next state SEND.
- **SEND**
  - Waits while txready=0. txclk=0 and txdata holds its last value.
  - When txready=1: txdata<=char(idx), txclk<=1, next state STROBE.
- **STROBE:** txclk high for exactly this one cycle; txclk<=0; next state WAIT.
- **WAIT**
  - Waits for txready=0; the UART must drop ready after a strobe.
  - Then: if idx==LAST, go to DONE; else idx<=idx+1 and go to SEND.
- **DONE:** frame_done=1 for one cycle, then IDLE.
- **Characters.**
  - idx 0..NIBBLES-1 selects nibble snapshot[WIDTH-1-4*idx -: 4].
  - Nibble 0–9 maps to 0x30–0x39; A–F maps to 0x41–0x46 (uppercase).
  - idx NIBBLES gives 0x0D and NIBBLES+1 gives 0x0A, present only when SEND_CRLF=1.
  - LAST = NIBBLES-1+2*SEND_CRLF.
- **Latency.** If a change is first sampled at edge N and txready=1 throughout, txclk is high in the cycle after edge N+2.
- **Minimum spacing.** Consecutive strobes are at least 3 cycles apart.
- **Frame consistency.** The frame always uses `snapshot`.
  - Changes to `value` mid-frame never corrupt the frame in flight.
  - The latest differing value is sent in the next frame.
  - Intermediate values that revert to last_sent before IDLE are not sent.
- **enable deasserted mid-frame:** the current frame completes; no new frame starts.
- **Reset mid-frame:** txclk drops immediately. After release, a full frame of the current value is sent from idx 0.
- **idx width:** $clog2(NIBBLES+2); no wrap-around within legal values.

Decomposition:
- Package `display_uart_pkg` holds:
  - the state typedef enum logic [2:0] {IDLE, LOAD, SEND, STROBE, WAIT, DONE};
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_M10=8'h37.
- Sub-module `hex_to_ascii`: combinational, 4-bit nibble in, 8-bit ASCII out. Instantiated once on the selected nibble.

Test Plan:
- Reset release, enable=1, value=0, UART model (ready drops 2 cycles after txclk, returns 5 cycles later) -> bytes 30×8, 0D, 0A; one frame_done; busy low afterwards.
- value=32'h1234ABCD -> bytes 31 32 33 34 41 42 43 44 0D 0A. First txclk in the cycle after edge N+2. Exactly 10 txclk pulses, each one cycle wide.
- value changes to 32'hDEADBEEF after the 3rd byte of the 1234ABCD frame -> that frame completes unchanged. Then frame 44 45 41 44 42 45 45 46 0D 0A; two frame_done pulses total.
- txready held low 50 cycles in SEND -> txclk=0, txdata stable, busy=1. On release, the transfer resumes with the next byte, none skipped or duplicated.
- Reset asserted mid-frame during the 5th byte -> txclk=0 and busy=0 in the same cycle. After release, the full frame is resent from the first digit.
- SEND_CRLF=0, value unchanged, send_req pulse -> exactly 8 bytes, no 0D/0A. A second send_req pulse while busy -> exactly one additional frame follows.
